zbt_voice_scheduler: RTL
========================

Name: zbt_voice_scheduler

Overview:
- Polyphonic playback sequencer for the projected-piano synth.
- On each AC97 `ready` strobe, it time-multiplexes the single ZBT read port across NUM_VOICES sample players, one slot per voice.
- It sums the returned 8-bit PCM samples with saturation and hands one mixed sample per frame to the AC97 output path.
- It sits between the key-detection logic (voice triggers and releases) and the ZBT/AC97 interfaces, replacing single-voice direct playback.

Parameters:
- NUM_VOICES, 4: number of simultaneous voices (power of 2, 2..8).
- RECORDING_LEN, 16384: samples per recording; one-shot length per voice.
- READ_LAT, 2: ZBT read latency in clocks, address to valid `zbt_rdata` (>=1).
- ADDR_W, 19: ZBT address width.

Ports:
- clock  in  1  27 MHz system clock.
- reset  in  1  asynchronous, active-low; 0 resets all state.
- ready  in  1  1-cycle strobe per AC97 frame (48 kHz).
- voice_trigger  in  NUM_VOICES  1-cycle pulse per voice: start playback from that voice's base.
- voice_release  in  NUM_VOICES  1-cycle pulse per voice: stop that voice.
- voice_base  in  NUM_VOICES*ADDR_W  flattened base address per voice; voice v occupies bits [v*ADDR_W +: ADDR_W].
- zbt_rdata  in  36  ZBT read data; sample = signed bits [7:0].
- zbt_addr  out  ADDR_W  ZBT address.
- zbt_we_n  out  1  ZBT write enable, active-low; held 1 (read only).
- to_ac97_data  out  8  mixed signed PCM sample.
- sample_valid  out  1  1-cycle pulse when `to_ac97_data` updates.
- voices_active  out  NUM_VOICES  per-voice playing flag.
- busy  out  1  1 while a frame sequence is in progress (state != IDLE).
- overrun  out  1  sticky; set when `ready` arrives while busy.

Behaviour:
- **Reset (reset=0, async):**
  - zbt_addr=0, zbt_we_n=1, to_ac97_data=0, sample_valid=0, voices_active=0, busy=0, overrun=0.
  - All offsets 0, pending trigger/release masks 0, state IDLE.
  - Reset mid-sequence aborts the frame; no sample_valid is issued.
- **Per-voice state:** active bit plus offset counter (clog2(RECORDING_LEN) bits). Voice address = voice_base[v] + offset, truncated to ADDR_W (wraps modulo 2^ADDR_W).
- **Trigger/release capture:**
  - Pulses are OR-ed into pending masks on any cycle.
  - Masks are applied and cleared only in IDLE on the cycle `ready`=1:
    - trigger: active=1, offset=0;
    - release: active=0.
  - Trigger and release for the same voice in the same frame: trigger wins.
  - Retrigger of an active voice restarts it at offset 0.
- **FSM states:** IDLE, ISSUE, WAIT, CAPTURE, MIX. Slot index v runs 0..NUM_VOICES-1.
  - IDLE: on `ready`, apply pending masks, clear accumulator, v=0, go to ISSUE. busy=0 only in IDLE.
  - ISSUE (1 cycle): zbt_addr = address of voice v if active; otherwise zbt_addr holds its previous value. Go to WAIT, or directly to CAPTURE if READ_LAT=1.
  - WAIT (READ_LAT-1 cycles).
  - CAPTURE (1 cycle, exactly READ_LAT cycles after ISSUE):
    - If voice v is active: accumulator += sign-extended zbt_rdata[7:0]; then offset+1.
    - If offset was RECORDING_LEN-1: offset=0 and active=0 (one-shot end).
    - Then v+1 and go to ISSUE; after the last voice, go to MIX.
  - MIX (1 cycle): saturate the accumulator (8+clog2(NUM_VOICES) bits, signed) to [-128,127]; register into to_ac97_data; pulse sample_valid; go to IDLE.
- **Fixed latency:**
  - Every slot takes READ_LAT+1 cycles whether the voice is active or not.
  - sample_valid is high exactly NUM_VOICES*(READ_LAT+1)+1 cycles after the cycle `ready` was high (13 at defaults).
  - No active voices: output 0 and sample_valid still pulses.
- **Overrun:**
  - `ready` while not IDLE is dropped and sets `overrun`; it clears only on reset.
  - `ready` on the MIX cycle counts as overrun.
- **voices_active** reflects the active bits directly, updated at IDLE application and at CAPTURE end.

Test Plan:
1. Voice 0 only, base=0x100, memory[a]=a[7:0] -> frames 1..3 output 0x00,0x01,0x02. sample_valid occurs 13 cycles after each ready. zbt_addr shows 0x100,0x101,0x102; zbt_we_n=1 throughout.
2. Voices 0..3 active, every returned sample =+100 -> to_ac97_data=127 (saturated). With every sample -100 -> 0x80 (-128). Voices returning +20,-5,0,+1 -> 16 (0x10).
3. RECORDING_LEN=4, voice 1 triggered -> exactly 4 samples read; voices_active[1] falls at CAPTURE of offset 3. Subsequent frames output 0.
4. Voice 2 retriggered at offset 10, and separately trigger+release pulsed in the same frame -> both cases restart at offset 0 with the voice active. Release alone -> voice inactive from the next frame.
5. Second `ready` asserted 5 cycles after the first -> overrun=1 and stays 1. Only one sample_valid is produced. The next legal ready proceeds normally.
6. reset driven 0 during WAIT of voice 2 -> all outputs return to reset values immediately (async). No sample_valid. After release, the first ready starts a clean frame.

Source files
------------

// File: rtl/zbt_voice_scheduler.sv
// rtl/zbt_voice_scheduler.sv - polyphonic ZBT sample sequencer and saturating mixer for the AC97 path
module zbt_voice_scheduler #(
  parameter int NUM_VOICES    = 4,
  parameter int RECORDING_LEN = 16384,
  parameter int READ_LAT      = 2,
  parameter int ADDR_W        = 19
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         ready,
  input  logic [NUM_VOICES-1:0]        voice_trigger,
  input  logic [NUM_VOICES-1:0]        voice_release,
  input  logic [NUM_VOICES*ADDR_W-1:0] voice_base,
  input  logic [35:0]                  zbt_rdata,
  output logic [ADDR_W-1:0]            zbt_addr,
  output logic                         zbt_we_n,
  output logic [7:0]                   to_ac97_data,
  output logic                         sample_valid,
  output logic [NUM_VOICES-1:0]        voices_active,
  output logic                         busy,
  output logic                         overrun
);

  localparam int VW    = $clog2(NUM_VOICES);
  localparam int OW    = $clog2(RECORDING_LEN);
  localparam int ACC_W = 8 + VW;
  localparam int WW    = $clog2(READ_LAT + 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CAPTURE, S_MIX} state_t;

  state_t                  state_q, state_d;
  logic [VW-1:0]           slot_q, slot_d;
  logic [WW-1:0]           wait_q, wait_d;
  logic [ACC_W-1:0]        acc_q, acc_d;
  logic [NUM_VOICES-1:0]   act_q, act_d;
  logic [OW-1:0]           off_q [NUM_VOICES];
  logic [OW-1:0]           off_d [NUM_VOICES];
  logic [NUM_VOICES-1:0]   trig_pend_q, trig_pend_d;
  logic [NUM_VOICES-1:0]   rel_pend_q, rel_pend_d;
  logic [ADDR_W-1:0]       zbt_addr_q, zbt_addr_d;
  logic [7:0]              dout_q, dout_d;
  logic                    sample_valid_q, sample_valid_d;
  logic                    overrun_q, overrun_d;
  logic                    issue_next;
  logic [ADDR_W-1:0]       base_arr [NUM_VOICES];
  logic                    unused_rdata_hi;

  // Only the low byte of the ZBT word carries PCM data.
  assign unused_rdata_hi = ^zbt_rdata[35:8];

  // Unflatten the per-voice base addresses.
  always_comb begin
    for (int v = 0; v < NUM_VOICES; v++) begin
      base_arr[v] = voice_base[v*ADDR_W +: ADDR_W];
    end
  end

  // Clamp the wide signed accumulator to the signed 8-bit output range.
  function automatic logic [7:0] sat8(input logic [ACC_W-1:0] a);
    if ((&a[ACC_W-1:7]) || !(|a[ACC_W-1:7])) begin
      return a[7:0];
    end
    return a[ACC_W-1] ? 8'h80 : 8'h7f;
  endfunction

  // Next-state logic: mask capture, slot sequencing, accumulation and mixing.
  always_comb begin
    state_d        = state_q;
    slot_d         = slot_q;
    wait_d         = wait_q;
    acc_d          = acc_q;
    act_d          = act_q;
    off_d          = off_q;
    trig_pend_d    = trig_pend_q | voice_trigger;
    rel_pend_d     = rel_pend_q | voice_release;
    zbt_addr_d     = zbt_addr_q;
    dout_d         = dout_q;
    sample_valid_d = 1'b0;
    overrun_d      = overrun_q | (ready && (state_q != S_IDLE));
    issue_next     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (ready) begin
          // Pulses arriving on this very cycle are folded in; trigger beats release.
          for (int v = 0; v < NUM_VOICES; v++) begin
            if (trig_pend_d[v]) begin
              act_d[v] = 1'b1;
              off_d[v] = '0;
            end else if (rel_pend_d[v]) begin
              act_d[v] = 1'b0;
            end
          end
          trig_pend_d = '0;
          rel_pend_d  = '0;
          acc_d       = '0;
          slot_d      = '0;
          state_d     = S_ISSUE;
          issue_next  = 1'b1;
        end
      end
      S_ISSUE: begin
        wait_d  = WW'(1);
        state_d = (READ_LAT == 1) ? S_CAPTURE : S_WAIT;
      end
      S_WAIT: begin
        if (wait_q >= WW'(READ_LAT - 1)) begin
          state_d = S_CAPTURE;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      S_CAPTURE: begin
        if (act_q[slot_q]) begin
          acc_d = acc_q + {{(ACC_W-8){zbt_rdata[7]}}, zbt_rdata[7:0]};
          if (off_q[slot_q] == OW'(RECORDING_LEN - 1)) begin
            off_d[slot_q] = '0;
            act_d[slot_q] = 1'b0;
          end else begin
            off_d[slot_q] = off_q[slot_q] + OW'(1);
          end
        end
        if (slot_q == VW'(NUM_VOICES - 1)) begin
          // Output registers load on entry to MIX so the pulse is visible during MIX.
          dout_d         = sat8(acc_d);
          sample_valid_d = 1'b1;
          state_d        = S_MIX;
        end else begin
          slot_d     = slot_q + VW'(1);
          state_d    = S_ISSUE;
          issue_next = 1'b1;
        end
      end
      S_MIX: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Address is registered on entry to ISSUE; idle slots leave the bus unchanged.
    if (issue_next && act_d[slot_d]) begin
      zbt_addr_d = base_arr[slot_d] + ADDR_W'(off_d[slot_d]);
    end
  end

  // State and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      slot_q         <= '0;
      wait_q         <= '0;
      acc_q          <= '0;
      act_q          <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        off_q[v] <= '0;
      end
      trig_pend_q    <= '0;
      rel_pend_q     <= '0;
      zbt_addr_q     <= '0;
      dout_q         <= '0;
      sample_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      slot_q         <= slot_d;
      wait_q         <= wait_d;
      acc_q          <= acc_d;
      act_q          <= act_d;
      off_q          <= off_d;
      trig_pend_q    <= trig_pend_d;
      rel_pend_q     <= rel_pend_d;
      zbt_addr_q     <= zbt_addr_d;
      dout_q         <= dout_d;
      sample_valid_q <= sample_valid_d;
      overrun_q      <= overrun_d;
    end
  end

  assign zbt_addr      = zbt_addr_q;
  assign zbt_we_n      = 1'b1;
  assign to_ac97_data  = dout_q;
  assign sample_valid  = sample_valid_q;
  assign voices_active = act_q;
  assign busy          = (state_q != S_IDLE);
  assign overrun       = overrun_q;

endmodule
